// File: rtl/anti_theft_pkg.sv
// ============================================================================
// anti_theft_pkg : interval codes, timer state encoding, default durations
// Rev 1.0
// ============================================================================
`default_nettype none

package anti_theft_pkg;

  localparam logic [1:0] INT_ARM    = 2'b00;
  localparam logic [1:0] INT_DRIVER = 2'b01;
  localparam logic [1:0] INT_PASS   = 2'b10;
  localparam logic [1:0] INT_ALARM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } timer_state_t;

  localparam logic [3:0] T_ARM_DEFAULT    = 4'd6;
  localparam logic [3:0] T_DRIVER_DEFAULT = 4'd8;
  localparam logic [3:0] T_PASS_DEFAULT   = 4'd15;
  localparam logic [3:0] T_ALARM_DEFAULT  = 4'd10;

endpackage

`default_nettype wire

// File: rtl/one_hz_gen.sv
// ============================================================================
// one_hz_gen : free-running prescaler, one-cycle tick every CLK_FREQ cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module one_hz_gen #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(CLK_FREQ - 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;
  logic          r_tick;

  always_comb begin
    w_next = r_count + 1'b1;
    if (i_clear || r_count == C_MAX) begin
      w_next = '0;
    end
  end

  // Tick is registered against the next count so it is high exactly while r_count == C_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_tick  <= (w_next == C_MAX);
    end
  end

  assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/anti_theft_timer.sv
// ============================================================================
// anti_theft_timer : countdown timer for the alarm FSM (expired, 1 Hz tick,
// seconds left). TIMER_REPROGRAM_EN enables the writable duration table.
// Rev 1.0
// ============================================================================
`default_nettype none

module anti_theft_timer
  import anti_theft_pkg::*;
#(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter logic [3:0] T_ARM_DEF    = T_ARM_DEFAULT,
  parameter logic [3:0] T_DRIVER_DEF = T_DRIVER_DEFAULT,
  parameter logic [3:0] T_PASS_DEF   = T_PASS_DEFAULT,
  parameter logic [3:0] T_ALARM_DEF  = T_ALARM_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       one_hz_enable,
  output logic [3:0] time_left
);

  timer_state_t r_state;
  logic         r_start_q;
  logic [1:0]   r_interval_q;
  logic [3:0]   r_time_left;
  logic         r_expired;
  logic [3:0]   w_entry;
  logic         w_load;
  logic         w_tick;

  assign w_load = start_timer && (!r_start_q || (interval != r_interval_q));

  one_hz_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_one_hz_gen (
    .clk     (clock),
    .rst     (reset),
    .i_clear (w_load),
    .o_tick  (w_tick)
  );

`ifdef TIMER_REPROGRAM_EN
  logic [3:0] r_table [4];

  // Non-blocking write: a load in the same cycle still reads the old entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_table[INT_ARM]    <= T_ARM_DEF;
      r_table[INT_DRIVER] <= T_DRIVER_DEF;
      r_table[INT_PASS]   <= T_PASS_DEF;
      r_table[INT_ALARM]  <= T_ALARM_DEF;
    end else if (reprogram) begin
      r_table[time_param_sel] <= time_value;
    end
  end

  assign w_entry = r_table[interval];
`else
  logic w_unused_reprog;
  assign w_unused_reprog = ^{reprogram, time_param_sel, time_value};

  always_comb begin
    w_entry = T_ARM_DEF;
    case (interval)
      INT_ARM:    w_entry = T_ARM_DEF;
      INT_DRIVER: w_entry = T_DRIVER_DEF;
      INT_PASS:   w_entry = T_PASS_DEF;
      INT_ALARM:  w_entry = T_ALARM_DEF;
      default:    w_entry = T_ARM_DEF;
    endcase
  end
`endif

  // Priority: start_timer low, then load, then the per-state countdown.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_start_q    <= 1'b0;
      r_interval_q <= 2'b00;
      r_time_left  <= 4'd0;
      r_expired    <= 1'b0;
    end else begin
      r_start_q    <= start_timer;
      r_interval_q <= interval;
      if (!start_timer) begin
        r_state     <= IDLE;
        r_time_left <= 4'd0;
        r_expired   <= 1'b0;
      end else if (w_load) begin
        r_state     <= COUNT;
        r_time_left <= w_entry;
        r_expired   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_time_left <= 4'd0;
            r_expired   <= 1'b0;
          end
          COUNT: begin
            if (r_time_left == 4'd0) begin
              r_state   <= DONE;
              r_expired <= 1'b1;
            end else if (w_tick) begin
              r_time_left <= r_time_left - 4'd1;
            end
          end
          DONE: begin
            r_time_left <= 4'd0;
            r_expired   <= 1'b1;
          end
          default: begin
            r_state     <= IDLE;
            r_time_left <= 4'd0;
            r_expired   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign expired       = r_expired;
  assign time_left     = r_time_left;
  assign one_hz_enable = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_anti_theft_timer.sv
// ============================================================================
// tb_anti_theft_timer : directed vectors with a queued scoreboard (CLK_FREQ=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_anti_theft_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic [3:0] time_left;

  anti_theft_timer #(
    .CLK_FREQ (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .interval       (interval),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .time_left      (time_left)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [3:0] tl;
    logic       ex;
    logic       tk;
    logic [2:0] mask;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // mask bit 0: time_left, bit 1: expired, bit 2: one_hz_enable
  task automatic expect_now(input string name, input logic [3:0] tl,
                            input logic ex, input logic tk, input logic [2:0] mask);
    exp_t e;
    e.cyc = cyc; e.tl = tl; e.ex = ex; e.tk = tk; e.mask = mask;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  // Monitor: pops every expectation due this cycle, compares on the falling edge.
  initial begin
    exp_t  e;
    string n;
    while (!done) begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n = sb_name.pop_front();
        if (e.mask[0]) begin
          checks++;
          if (time_left !== e.tl) begin
            errors++;
            $display("FAIL %s time_left: got %0d expected %0d", n, time_left, e.tl);
          end
        end
        if (e.mask[1]) begin
          checks++;
          if (expired !== e.ex) begin
            errors++;
            $display("FAIL %s expired: got %0b expected %0b", n, expired, e.ex);
          end
        end
        if (e.mask[2]) begin
          checks++;
          if (one_hz_enable !== e.tk) begin
            errors++;
            $display("FAIL %s one_hz_enable: got %0b expected %0b", n, one_hz_enable, e.tk);
          end
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; start_timer = 1'b0; interval = 2'b00;
    reprogram = 1'b0; time_param_sel = 2'b00; time_value = 4'd0;

    // Reset state
    step(2);
    expect_now("reset", 4'd0, 1'b0, 1'b0, 3'b111);

    // 1: driver delay 8 s, expires and holds
    reset = 1'b0; start_timer = 1'b1; interval = 2'b01;
    step(1);  expect_now("t1_load", 4'd8, 1'b0, 1'b0, 3'b111);
    step(3);  expect_now("t1_first_tick", 4'd8, 1'b0, 1'b1, 3'b111);
    step(1);  expect_now("t1_dec", 4'd7, 1'b0, 1'b0, 3'b111);
    step(27); expect_now("t1_one_left", 4'd1, 1'b0, 1'b0, 3'b011);
    step(1);  expect_now("t1_zero", 4'd0, 1'b0, 1'b0, 3'b011);
    step(1);  expect_now("t1_expired", 4'd0, 1'b1, 1'b0, 3'b011);
    step(5);  expect_now("t1_hold", 4'd0, 1'b1, 1'b0, 3'b011);

    // 2: free run, tick every 4 cycles after reset
    start_timer = 1'b0; reset = 1'b1;
    step(1);  reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      expect_now("t2_freerun", 4'd0, 1'b0, ((i % 4) == 3), 3'b111);
    end

    // 3: interval change 01 -> 11 while counting reloads
    start_timer = 1'b1; interval = 2'b01;
    step(1);  expect_now("t3_load", 4'd8, 1'b0, 1'b0, 3'b011);
    step(12); expect_now("t3_at5", 4'd5, 1'b0, 1'b0, 3'b011);
    interval = 2'b11;
    step(1);  expect_now("t3_reload", 4'd10, 1'b0, 1'b0, 3'b011);
    step(4);  expect_now("t3_dec", 4'd9, 1'b0, 1'b0, 3'b011);

    // 4: drop at 3, re-raise with arm interval
    step(24); expect_now("t4_at3", 4'd3, 1'b0, 1'b0, 3'b011);
    start_timer = 1'b0;
    step(1);  expect_now("t4_idle", 4'd0, 1'b0, 1'b0, 3'b011);
    start_timer = 1'b1; interval = 2'b00;
    step(1);  expect_now("t4_arm", 4'd6, 1'b0, 1'b0, 3'b011);

    // 5: reprogram passenger entry mid-count on driver
    start_timer = 1'b0;
    step(1);
    start_timer = 1'b1; interval = 2'b01;
    step(1);  expect_now("t5_load", 4'd8, 1'b0, 1'b0, 3'b011);
    reprogram = 1'b1; time_param_sel = 2'b10; time_value = 4'd3;
    step(1);  expect_now("t5_unaffected", 4'd8, 1'b0, 1'b0, 3'b011);
    reprogram = 1'b0;
    step(3);  expect_now("t5_dec", 4'd7, 1'b0, 1'b0, 3'b011);
    interval = 2'b10;
`ifdef TIMER_REPROGRAM_EN
    step(1);  expect_now("t5_pass_new", 4'd3, 1'b0, 1'b0, 3'b011);
`else
    step(1);  expect_now("t5_pass_def", 4'd15, 1'b0, 1'b0, 3'b011);
`endif

    // Reprogram and load of the same entry in one cycle: load sees old value
    start_timer = 1'b0;
    step(1);
    start_timer = 1'b1; interval = 2'b11;
    reprogram = 1'b1; time_param_sel = 2'b11; time_value = 4'd2;
    step(1);  expect_now("same_cycle_old", 4'd10, 1'b0, 1'b0, 3'b011);
    reprogram = 1'b0; start_timer = 1'b0;
    step(1);
    start_timer = 1'b1;
`ifdef TIMER_REPROGRAM_EN
    step(1);  expect_now("same_cycle_next", 4'd2, 1'b0, 1'b0, 3'b011);
    // Zero-second entry expires one cycle after the load
    start_timer = 1'b0; reprogram = 1'b1; time_param_sel = 2'b00; time_value = 4'd0;
    step(1);
    reprogram = 1'b0; start_timer = 1'b1; interval = 2'b00;
    step(1);  expect_now("zero_load", 4'd0, 1'b0, 1'b0, 3'b011);
    step(1);  expect_now("zero_expired", 4'd0, 1'b1, 1'b0, 3'b011);
`else
    step(1);  expect_now("same_cycle_next", 4'd10, 1'b0, 1'b0, 3'b011);
`endif

    // 6: reset while DONE with start held high
    start_timer = 1'b0;
    step(1);
    start_timer = 1'b1; interval = 2'b00;
    step(1);
    n = 0;
    while (!expired && n < 40) begin
      step(1);
      n++;
    end
    expect_now("t6_done", 4'd0, 1'b1, 1'b0, 3'b011);
    reset = 1'b1;
    step(1);  expect_now("t6_reset", 4'd0, 1'b0, 1'b0, 3'b111);
    reset = 1'b0;
    step(1);  expect_now("t6_arm_default", 4'd6, 1'b0, 1'b0, 3'b011);
    interval = 2'b10;
    step(1);  expect_now("t6_pass_default", 4'd15, 1'b0, 1'b0, 3'b011);
    interval = 2'b11;
    step(1);  expect_now("t6_alarm_default", 4'd10, 1'b0, 1'b0, 3'b011);

    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
